pipe_decode_ctrl: RTL and testbench
===================================

Name: pipe_decode_ctrl

Overview:
- Registered instruction-decode stage for the pipelined core. Sits between the IF/ID instruction register and the EX stage.
- Decodes opcode/rt/funct into the Core.vh control bundle and registers it with valid/stall/flush semantics.
- Extends the base MIPS subset with HI/LO multiply/divide instructions.
- Contains a multi-cycle MDU sequencer that tracks the in-flight mult/div and blocks dependent instructions until it completes.

Parameters:
- MUL_LAT, 3: cycles the MDU needs for mult/multu; must be >=1.
- DIV_LAT, 32: cycles the MDU needs for div/divu; must be >=1.
- CNT_W, 6: MDU counter width; must hold max(MUL_LAT, DIV_LAT)-1.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction present on opcode/rt/funct
- in_ready  out  1  stage accepts the instruction this cycle
- opcode  in  6  instr[31:26]
- rt  in  5  instr[20:16]
- funct  in  6  instr[5:0]
- stall  in  1  downstream hazard; hold the output register
- flush  in  1  squash the output register (branch taken or exception)
- out_valid  out  1  control bundle valid for EX
- op_wtg  out  `WTG_OP_BIT  next-PC op
- op_alu  out  `ALU_OP_BIT  ALU op
- op_datamem  out  `DM_OP_BIT  memory access size/sign
- w_en_regfile, w_en_datamem, syscall_en, is_jump, is_branch  out  1 each
- mux_regfile_req_w  out  `MUX_RF_REQW_BIT
- mux_regfile_data_w  out  `MUX_RF_DATAW_BIT
- mux_alu_data_y  out  `MUX_ALU_DATAY_BIT
- mdu_start  out  1  one-cycle start pulse to the MDU
- mdu_op  out  2  0 mult, 1 multu, 2 div, 3 divu
- hilo_rd  out  2  0 none, 1 mfhi, 2 mflo
- hilo_wr  out  2  0 none, 1 mthi, 2 mtlo
- mdu_busy  out  1  MDU operation in flight
- illegal_inst  out  1  undecodable instruction

Behaviour:
- Base decode (combinational, before the register); these are the defaults unless an entry below overrides them: `WTG_OP_J32, `ALU_OP_AND, `DM_OP_WD, w_en_regfile=1, data_w=ALU, req_w=RT, data_y=EXTS.
  - R-type: req_w=RD, data_y=RFB, ALU op per funct (sll/srl/sra/sllv/srlv/srav/add(u)/sub(u)/and/or/xor/nor/slt/sltu).
  - jr: is_jump, no RF write. syscall: syscall_en, no RF write.
  - REGIMM: rt[0]=0 gives BLTZ, rt[0]=1 gives BGEZ; is_branch; no RF write.
  - j: J26, is_jump, no RF write. jal: J26, is_jump, req_w=31, data_w=PC4.
  - beq/bne/blez/bgtz: matching WTG op, is_branch, no RF write.
  - addi(u)=ADD, slti=SLT, sltiu=SLTU. andi/ori/xori use data_y=EXTZ. lui=LUI.
  - Loads lb/lh/lw/lbu/lhu: ADD, data_w=DM, DM op SB/SH/WD/UB/UH.
  - Stores sb/sh/sw: ADD, w_en_datamem=1, no RF write.
- New R-type funct codes:
  - mult 011000, multu 011001, div 011010, divu 011011: mdu_start, mdu_op, no RF write.
  - mfhi 010000 / mflo 010010: hilo_rd=1/2, req_w=RD, RF write.
  - mthi 010001 / mtlo 010011: hilo_wr=1/2, no RF write.
- Any other opcode/funct: illegal_inst=1, out_valid=1, all write/jump/branch/syscall enables 0.
- MDU hazard (combinational): in IDLE=0. In RUN=1 when the instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- in_ready = !stall & !hazard.
- Output register update; priority rst > flush > stall > load:
  - rst or flush: out_valid=0; all enables, mdu_start, hilo_* and illegal_inst = 0; op fields at their decode defaults.
  - stall: hold every registered output. mdu_start is forced to 0 after its first cycle, so the pulse is never repeated.
  - else if in_valid & in_ready: load the decode, out_valid=1.
  - else: bubble (as for flush).
- Latency: 1 cycle from acceptance to out_valid.
- MDU FSM: states IDLE and RUN; mdu_busy = (state==RUN).
  - IDLE to RUN when a mult/div is accepted. Counter loads MUL_LAT-1 or DIV_LAT-1, and mdu_start rises in the same cycle as out_valid.
  - In RUN, the counter decrements each cycle. When counter==0, the next state is IDLE.
  - A hazard instruction presented in the last RUN cycle is still blocked; it is accepted the following cycle.
- Flush does not abort RUN: the MDU operation is already committed.
- Reset mid-RUN returns to IDLE with counter=0.
- LAT=1: RUN lasts exactly one cycle.

Test Plan:
- Reset, then addu (op 0, funct 100001) -> one cycle later out_valid=1, op_alu=ADD, req_w=RD, data_y=RFB, w_en_regfile=1.
- div (funct 011010), then mflo presented immediately -> mdu_start pulses once; mdu_busy high 32 cycles; in_ready=0 for mflo until busy falls; mflo out_valid on the cycle after busy falls, with hilo_rd=2.
- mult followed by independent lw -> lw accepted the next cycle, out_valid=1, data_w=DM, DM_OP_WD, while mdu_busy=1 for 3 cycles.
- Load beq, then assert stall 2 cycles with flush in the second -> outputs held for the first cycle, out_valid=0 after the flush, is_branch=0.
- Opcode 111111 -> out_valid=1, illegal_inst=1, w_en_regfile=0, w_en_datamem=0.
- rst asserted mid-div -> next cycle mdu_busy=0, out_valid=0, in_ready=1 once rst drops.

Source files
------------

// File: rtl/pipe_decode_ctrl.sv
// Registered ID stage: decodes opcode/rt/funct into the EX control bundle and
// sequences multi-cycle HI/LO multiply/divide operations.
`ifndef PIPE_DECODE_CTRL_DEFS
`define PIPE_DECODE_CTRL_DEFS
`define WTG_OP_BIT        3
`define WTG_OP_J32        3'd0
`define WTG_OP_J26        3'd1
`define WTG_OP_BEQ        3'd2
`define WTG_OP_BNE        3'd3
`define WTG_OP_BLEZ       3'd4
`define WTG_OP_BGTZ       3'd5
`define WTG_OP_BLTZ       3'd6
`define WTG_OP_BGEZ       3'd7
`define ALU_OP_BIT        4
`define ALU_OP_ADD        4'd0
`define ALU_OP_SUB        4'd1
`define ALU_OP_AND        4'd2
`define ALU_OP_OR         4'd3
`define ALU_OP_XOR        4'd4
`define ALU_OP_NOR        4'd5
`define ALU_OP_SLT        4'd6
`define ALU_OP_SLTU       4'd7
`define ALU_OP_SLL        4'd8
`define ALU_OP_SRL        4'd9
`define ALU_OP_SRA        4'd10
`define ALU_OP_SLLV       4'd11
`define ALU_OP_SRLV       4'd12
`define ALU_OP_SRAV       4'd13
`define ALU_OP_LUI        4'd14
`define DM_OP_BIT         3
`define DM_OP_WD          3'd0
`define DM_OP_SB          3'd1
`define DM_OP_SH          3'd2
`define DM_OP_UB          3'd3
`define DM_OP_UH          3'd4
`define MUX_RF_REQW_BIT   2
`define MUX_RF_REQW_RT    2'd0
`define MUX_RF_REQW_RD    2'd1
`define MUX_RF_REQW_31    2'd2
`define MUX_RF_DATAW_BIT  2
`define MUX_RF_DATAW_ALU  2'd0
`define MUX_RF_DATAW_DM   2'd1
`define MUX_RF_DATAW_PC4  2'd2
`define MUX_ALU_DATAY_BIT 2
`define MUX_ALU_DATAY_RFB  2'd0
`define MUX_ALU_DATAY_EXTS 2'd1
`define MUX_ALU_DATAY_EXTZ 2'd2
`endif

// MDU sequencer states
//   state | meaning
//   IDLE  | no mult/div in flight, HI/LO instructions pass freely
//   RUN   | mult/div in flight, cnt counts down to the last busy cycle
module pipe_decode_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [5:0]                      opcode,
  input  logic [4:0]                      rt,
  input  logic [5:0]                      funct,
  input  logic                            stall,
  input  logic                            flush,
  output logic                            out_valid,
  output logic [`WTG_OP_BIT-1:0]          op_wtg,
  output logic [`ALU_OP_BIT-1:0]          op_alu,
  output logic [`DM_OP_BIT-1:0]           op_datamem,
  output logic                            w_en_regfile,
  output logic                            w_en_datamem,
  output logic                            syscall_en,
  output logic                            is_jump,
  output logic                            is_branch,
  output logic [`MUX_RF_REQW_BIT-1:0]     mux_regfile_req_w,
  output logic [`MUX_RF_DATAW_BIT-1:0]    mux_regfile_data_w,
  output logic [`MUX_ALU_DATAY_BIT-1:0]   mux_alu_data_y,
  output logic                            mdu_start,
  output logic [1:0]                      mdu_op,
  output logic [1:0]                      hilo_rd,
  output logic [1:0]                      hilo_wr,
  output logic                            mdu_busy,
  output logic                            illegal_inst
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_REGIMM = 6'b000001,
                         OP_J     = 6'b000010, OP_JAL    = 6'b000011,
                         OP_BEQ   = 6'b000100, OP_BNE    = 6'b000101,
                         OP_BLEZ  = 6'b000110, OP_BGTZ   = 6'b000111,
                         OP_ADDI  = 6'b001000, OP_ADDIU  = 6'b001001,
                         OP_SLTI  = 6'b001010, OP_SLTIU  = 6'b001011,
                         OP_ANDI  = 6'b001100, OP_ORI    = 6'b001101,
                         OP_XORI  = 6'b001110, OP_LUI    = 6'b001111,
                         OP_LB    = 6'b100000, OP_LH     = 6'b100001,
                         OP_LW    = 6'b100011, OP_LBU    = 6'b100100,
                         OP_LHU   = 6'b100101, OP_SB     = 6'b101000,
                         OP_SH    = 6'b101001, OP_SW     = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000, F_SRL   = 6'b000010,
                         F_SRA  = 6'b000011, F_SLLV  = 6'b000100,
                         F_SRLV = 6'b000110, F_SRAV  = 6'b000111,
                         F_JR   = 6'b001000, F_SYSC  = 6'b001100,
                         F_MFHI = 6'b010000, F_MTHI  = 6'b010001,
                         F_MFLO = 6'b010010, F_MTLO  = 6'b010011,
                         F_MULT = 6'b011000, F_MULTU = 6'b011001,
                         F_DIV  = 6'b011010, F_DIVU  = 6'b011011,
                         F_ADD  = 6'b100000, F_ADDU  = 6'b100001,
                         F_SUB  = 6'b100010, F_SUBU  = 6'b100011,
                         F_AND  = 6'b100100, F_OR    = 6'b100101,
                         F_XOR  = 6'b100110, F_NOR   = 6'b100111,
                         F_SLT  = 6'b101010, F_SLTU  = 6'b101011;

  logic             state;
  logic [CNT_W-1:0] cnt;
  logic             hazard;
  logic             load;
  logic             unused_rt;

  logic [`WTG_OP_BIT-1:0]        d_wtg;
  logic [`ALU_OP_BIT-1:0]        d_alu;
  logic [`DM_OP_BIT-1:0]         d_dm;
  logic                          d_wrf, d_wdm, d_sys, d_jmp, d_br, d_ill, d_mstart;
  logic [`MUX_RF_REQW_BIT-1:0]   d_reqw;
  logic [`MUX_RF_DATAW_BIT-1:0]  d_dataw;
  logic [`MUX_ALU_DATAY_BIT-1:0] d_datay;
  logic [1:0]                    d_mop, d_hrd, d_hwr;

  assign unused_rt = ^rt[4:1];

  always_comb begin
    d_wtg    = `WTG_OP_J32;
    d_alu    = `ALU_OP_AND;
    d_dm     = `DM_OP_WD;
    d_wrf    = 1'b1;
    d_wdm    = 1'b0;
    d_sys    = 1'b0;
    d_jmp    = 1'b0;
    d_br     = 1'b0;
    d_ill    = 1'b0;
    d_mstart = 1'b0;
    d_reqw   = `MUX_RF_REQW_RT;
    d_dataw  = `MUX_RF_DATAW_ALU;
    d_datay  = `MUX_ALU_DATAY_EXTS;
    d_mop    = 2'd0;
    d_hrd    = 2'd0;
    d_hwr    = 2'd0;
    case (opcode)
      OP_RTYPE: begin
        d_reqw  = `MUX_RF_REQW_RD;
        d_datay = `MUX_ALU_DATAY_RFB;
        case (funct)
          F_SLL:         d_alu = `ALU_OP_SLL;
          F_SRL:         d_alu = `ALU_OP_SRL;
          F_SRA:         d_alu = `ALU_OP_SRA;
          F_SLLV:        d_alu = `ALU_OP_SLLV;
          F_SRLV:        d_alu = `ALU_OP_SRLV;
          F_SRAV:        d_alu = `ALU_OP_SRAV;
          F_ADD, F_ADDU: d_alu = `ALU_OP_ADD;
          F_SUB, F_SUBU: d_alu = `ALU_OP_SUB;
          F_AND:         d_alu = `ALU_OP_AND;
          F_OR:          d_alu = `ALU_OP_OR;
          F_XOR:         d_alu = `ALU_OP_XOR;
          F_NOR:         d_alu = `ALU_OP_NOR;
          F_SLT:         d_alu = `ALU_OP_SLT;
          F_SLTU:        d_alu = `ALU_OP_SLTU;
          F_JR:          begin d_jmp = 1'b1; d_wrf = 1'b0; end
          F_SYSC:        begin d_sys = 1'b1; d_wrf = 1'b0; end
          F_MFHI:        d_hrd = 2'd1;
          F_MFLO:        d_hrd = 2'd2;
          F_MTHI:        begin d_hwr = 2'd1; d_wrf = 1'b0; end
          F_MTLO:        begin d_hwr = 2'd2; d_wrf = 1'b0; end
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            d_mstart = 1'b1;
            d_mop    = funct[1:0];
            d_wrf    = 1'b0;
          end
          default:       d_ill = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        d_wtg = rt[0] ? `WTG_OP_BGEZ : `WTG_OP_BLTZ;
        d_br  = 1'b1;
        d_wrf = 1'b0;
      end
      OP_J:   begin d_wtg = `WTG_OP_J26; d_jmp = 1'b1; d_wrf = 1'b0; end
      OP_JAL: begin
        d_wtg   = `WTG_OP_J26;
        d_jmp   = 1'b1;
        d_reqw  = `MUX_RF_REQW_31;
        d_dataw = `MUX_RF_DATAW_PC4;
      end
      OP_BEQ:  begin d_wtg = `WTG_OP_BEQ;  d_br = 1'b1; d_wrf = 1'b0; end
      OP_BNE:  begin d_wtg = `WTG_OP_BNE;  d_br = 1'b1; d_wrf = 1'b0; end
      OP_BLEZ: begin d_wtg = `WTG_OP_BLEZ; d_br = 1'b1; d_wrf = 1'b0; end
      OP_BGTZ: begin d_wtg = `WTG_OP_BGTZ; d_br = 1'b1; d_wrf = 1'b0; end
      OP_ADDI, OP_ADDIU: d_alu = `ALU_OP_ADD;
      OP_SLTI:  d_alu = `ALU_OP_SLT;
      OP_SLTIU: d_alu = `ALU_OP_SLTU;
      OP_ANDI:  begin d_alu = `ALU_OP_AND; d_datay = `MUX_ALU_DATAY_EXTZ; end
      OP_ORI:   begin d_alu = `ALU_OP_OR;  d_datay = `MUX_ALU_DATAY_EXTZ; end
      OP_XORI:  begin d_alu = `ALU_OP_XOR; d_datay = `MUX_ALU_DATAY_EXTZ; end
      OP_LUI:   d_alu = `ALU_OP_LUI;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        d_alu   = `ALU_OP_ADD;
        d_dataw = `MUX_RF_DATAW_DM;
        case (opcode)
          OP_LB:   d_dm = `DM_OP_SB;
          OP_LH:   d_dm = `DM_OP_SH;
          OP_LBU:  d_dm = `DM_OP_UB;
          OP_LHU:  d_dm = `DM_OP_UH;
          default: d_dm = `DM_OP_WD;
        endcase
      end
      OP_SB, OP_SH, OP_SW: begin
        d_alu = `ALU_OP_ADD;
        d_wdm = 1'b1;
        d_wrf = 1'b0;
        case (opcode)
          OP_SB:   d_dm = `DM_OP_SB;
          OP_SH:   d_dm = `DM_OP_SH;
          default: d_dm = `DM_OP_WD;
        endcase
      end
      default: d_ill = 1'b1;
    endcase
    // Illegal encodings leave the bundle at its inert defaults so nothing downstream fires.
    if (d_ill) begin
      d_wtg   = `WTG_OP_J32;
      d_alu   = `ALU_OP_AND;
      d_dm    = `DM_OP_WD;
      d_reqw  = `MUX_RF_REQW_RT;
      d_dataw = `MUX_RF_DATAW_ALU;
      d_datay = `MUX_ALU_DATAY_EXTS;
      d_wrf   = 1'b0;
    end
  end

  assign hazard   = (state == S_RUN) && (opcode == OP_RTYPE) &&
                    ((funct[5:2] == 4'b0110) || (funct[5:2] == 4'b0100));
  assign in_ready = !stall && !hazard;
  assign load     = in_valid && in_ready && !flush;
  assign mdu_busy = (state == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (load && d_mstart) begin
          state <= S_RUN;
          cnt   <= funct[1] ? DIV_CNT : MUL_CNT;
        end
        default: if (cnt == '0) state <= S_IDLE;
                 else cnt <= cnt - CNT_W'(1);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush || (!stall && !load)) begin
      out_valid          <= 1'b0;
      op_wtg             <= `WTG_OP_J32;
      op_alu             <= `ALU_OP_AND;
      op_datamem         <= `DM_OP_WD;
      w_en_regfile       <= 1'b0;
      w_en_datamem       <= 1'b0;
      syscall_en         <= 1'b0;
      is_jump            <= 1'b0;
      is_branch          <= 1'b0;
      mux_regfile_req_w  <= `MUX_RF_REQW_RT;
      mux_regfile_data_w <= `MUX_RF_DATAW_ALU;
      mux_alu_data_y     <= `MUX_ALU_DATAY_EXTS;
      mdu_start          <= 1'b0;
      mdu_op             <= 2'd0;
      hilo_rd            <= 2'd0;
      hilo_wr            <= 2'd0;
      illegal_inst       <= 1'b0;
    end else if (stall) begin
      mdu_start <= 1'b0;
    end else begin
      out_valid          <= 1'b1;
      op_wtg             <= d_wtg;
      op_alu             <= d_alu;
      op_datamem         <= d_dm;
      w_en_regfile       <= d_wrf;
      w_en_datamem       <= d_wdm;
      syscall_en         <= d_sys;
      is_jump            <= d_jmp;
      is_branch          <= d_br;
      mux_regfile_req_w  <= d_reqw;
      mux_regfile_data_w <= d_dataw;
      mux_alu_data_y     <= d_datay;
      mdu_start          <= d_mstart;
      mdu_op             <= d_mop;
      hilo_rd            <= d_hrd;
      hilo_wr            <= d_hwr;
      illegal_inst       <= d_ill;
    end
  end

endmodule

// File: tb/tb_pipe_decode_ctrl.sv
// Directed bench for pipe_decode_ctrl: decode vector table plus MDU, stall,
// flush and reset sequences.
module tb_pipe_decode_ctrl;

  // Encodings of the control bundle fields as seen by EX.
  localparam logic [2:0] W_J32 = 0, W_J26 = 1, W_BEQ = 2, W_BGTZ = 5, W_BLTZ = 6, W_BGEZ = 7;
  localparam logic [3:0] A_ADD = 0, A_SUB = 1, A_AND = 2, A_OR = 3, A_NOR = 5, A_SLT = 6,
                         A_SLTU = 7, A_SRA = 10, A_SRLV = 12, A_LUI = 14;
  localparam logic [2:0] D_WD = 0, D_SB = 1, D_SH = 2, D_UB = 3;
  localparam logic [1:0] RQ_RT = 0, RQ_RD = 1, RQ_31 = 2;
  localparam logic [1:0] DW_ALU = 0, DW_DM = 1, DW_PC4 = 2;
  localparam logic [1:0] DY_RFB = 0, DY_EXTS = 1, DY_EXTZ = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic [4:0] rt = '0;
  logic in_ready, out_valid, w_en_regfile, w_en_datamem, syscall_en, is_jump, is_branch;
  logic mdu_start, mdu_busy, illegal_inst;
  logic [2:0] op_wtg, op_datamem;
  logic [3:0] op_alu;
  logic [1:0] mux_regfile_req_w, mux_regfile_data_w, mux_alu_data_y, mdu_op, hilo_rd, hilo_wr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_decode_ctrl #(.MUL_LAT(3), .DIV_LAT(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rt(rt), .funct(funct), .stall(stall), .flush(flush),
    .out_valid(out_valid), .op_wtg(op_wtg), .op_alu(op_alu), .op_datamem(op_datamem),
    .w_en_regfile(w_en_regfile), .w_en_datamem(w_en_datamem), .syscall_en(syscall_en),
    .is_jump(is_jump), .is_branch(is_branch), .mux_regfile_req_w(mux_regfile_req_w),
    .mux_regfile_data_w(mux_regfile_data_w), .mux_alu_data_y(mux_alu_data_y),
    .mdu_start(mdu_start), .mdu_op(mdu_op), .hilo_rd(hilo_rd), .hilo_wr(hilo_wr),
    .mdu_busy(mdu_busy), .illegal_inst(illegal_inst)
  );

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [4:0] rt;
    logic [5:0] fn;
    logic [25:0] exp;
  } vec_t;

  vec_t vecs[$];

  // flags = {w_en_regfile, w_en_datamem, syscall_en, is_jump, is_branch, illegal_inst}
  task automatic add(input string name, input logic [5:0] op, input logic [4:0] r,
                     input logic [5:0] fn, input logic [2:0] wtg, input logic [3:0] alu,
                     input logic [2:0] dm, input logic [1:0] rq, input logic [1:0] dw,
                     input logic [1:0] dy, input logic [5:0] flags, input logic [1:0] hrd,
                     input logic [1:0] hwr);
    vec_t v;
    v.name = name; v.op = op; v.rt = r; v.fn = fn;
    v.exp  = {wtg, alu, dm, rq, dw, dy, flags, hrd, hwr};
    vecs.push_back(v);
  endtask

  function automatic logic [25:0] bundle();
    return {op_wtg, op_alu, op_datamem, mux_regfile_req_w, mux_regfile_data_w, mux_alu_data_y,
            w_en_regfile, w_en_datamem, syscall_en, is_jump, is_branch, illegal_inst,
            hilo_rd, hilo_wr};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] r, input logic [5:0] fn);
    in_valid = v; opcode = op; rt = r; funct = fn;
  endtask

  initial begin
    int bc;
    int pulses;
    int blocked;
    int guard;

    add("addu",    6'b000000, 5'd0, 6'b100001, W_J32, A_ADD,  D_WD, RQ_RD, DW_ALU, DY_RFB,  6'b100000, 2'd0, 2'd0);
    add("sub",     6'b000000, 5'd0, 6'b100010, W_J32, A_SUB,  D_WD, RQ_RD, DW_ALU, DY_RFB,  6'b100000, 2'd0, 2'd0);
    add("sltu",    6'b000000, 5'd0, 6'b101011, W_J32, A_SLTU, D_WD, RQ_RD, DW_ALU, DY_RFB,  6'b100000, 2'd0, 2'd0);
    add("sra",     6'b000000, 5'd0, 6'b000011, W_J32, A_SRA,  D_WD, RQ_RD, DW_ALU, DY_RFB,  6'b100000, 2'd0, 2'd0);
    add("srlv",    6'b000000, 5'd0, 6'b000110, W_J32, A_SRLV, D_WD, RQ_RD, DW_ALU, DY_RFB,  6'b100000, 2'd0, 2'd0);
    add("nor",     6'b000000, 5'd0, 6'b100111, W_J32, A_NOR,  D_WD, RQ_RD, DW_ALU, DY_RFB,  6'b100000, 2'd0, 2'd0);
    add("jr",      6'b000000, 5'd0, 6'b001000, W_J32, A_AND,  D_WD, RQ_RD, DW_ALU, DY_RFB,  6'b000100, 2'd0, 2'd0);
    add("syscall", 6'b000000, 5'd0, 6'b001100, W_J32, A_AND,  D_WD, RQ_RD, DW_ALU, DY_RFB,  6'b001000, 2'd0, 2'd0);
    add("mfhi",    6'b000000, 5'd0, 6'b010000, W_J32, A_AND,  D_WD, RQ_RD, DW_ALU, DY_RFB,  6'b100000, 2'd1, 2'd0);
    add("mtlo",    6'b000000, 5'd0, 6'b010011, W_J32, A_AND,  D_WD, RQ_RD, DW_ALU, DY_RFB,  6'b000000, 2'd0, 2'd2);
    add("bad_fn",  6'b000000, 5'd0, 6'b000001, W_J32, A_AND,  D_WD, RQ_RT, DW_ALU, DY_EXTS, 6'b000001, 2'd0, 2'd0);
    add("j",       6'b000010, 5'd0, 6'b000000, W_J26, A_AND,  D_WD, RQ_RT, DW_ALU, DY_EXTS, 6'b000100, 2'd0, 2'd0);
    add("jal",     6'b000011, 5'd0, 6'b000000, W_J26, A_AND,  D_WD, RQ_31, DW_PC4, DY_EXTS, 6'b100100, 2'd0, 2'd0);
    add("beq",     6'b000100, 5'd0, 6'b000000, W_BEQ, A_AND,  D_WD, RQ_RT, DW_ALU, DY_EXTS, 6'b000010, 2'd0, 2'd0);
    add("bgtz",    6'b000111, 5'd0, 6'b000000, W_BGTZ,A_AND,  D_WD, RQ_RT, DW_ALU, DY_EXTS, 6'b000010, 2'd0, 2'd0);
    add("bltz",    6'b000001, 5'd0, 6'b000000, W_BLTZ,A_AND,  D_WD, RQ_RT, DW_ALU, DY_EXTS, 6'b000010, 2'd0, 2'd0);
    add("bgez",    6'b000001, 5'd1, 6'b000000, W_BGEZ,A_AND,  D_WD, RQ_RT, DW_ALU, DY_EXTS, 6'b000010, 2'd0, 2'd0);
    add("addiu",   6'b001001, 5'd0, 6'b000000, W_J32, A_ADD,  D_WD, RQ_RT, DW_ALU, DY_EXTS, 6'b100000, 2'd0, 2'd0);
    add("slti",    6'b001010, 5'd0, 6'b000000, W_J32, A_SLT,  D_WD, RQ_RT, DW_ALU, DY_EXTS, 6'b100000, 2'd0, 2'd0);
    add("ori",     6'b001101, 5'd0, 6'b000000, W_J32, A_OR,   D_WD, RQ_RT, DW_ALU, DY_EXTZ, 6'b100000, 2'd0, 2'd0);
    add("lui",     6'b001111, 5'd0, 6'b000000, W_J32, A_LUI,  D_WD, RQ_RT, DW_ALU, DY_EXTS, 6'b100000, 2'd0, 2'd0);
    add("lh",      6'b100001, 5'd0, 6'b000000, W_J32, A_ADD,  D_SH, RQ_RT, DW_DM,  DY_EXTS, 6'b100000, 2'd0, 2'd0);
    add("lbu",     6'b100100, 5'd0, 6'b000000, W_J32, A_ADD,  D_UB, RQ_RT, DW_DM,  DY_EXTS, 6'b100000, 2'd0, 2'd0);
    add("sw",      6'b101011, 5'd0, 6'b000000, W_J32, A_ADD,  D_WD, RQ_RT, DW_ALU, DY_EXTS, 6'b010000, 2'd0, 2'd0);
    add("sb",      6'b101000, 5'd0, 6'b000000, W_J32, A_ADD,  D_SB, RQ_RT, DW_ALU, DY_EXTS, 6'b010000, 2'd0, 2'd0);
    add("bad_op",  6'b111111, 5'd0, 6'b000000, W_J32, A_AND,  D_WD, RQ_RT, DW_ALU, DY_EXTS, 6'b000001, 2'd0, 2'd0);

    // Reset state
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(mdu_busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_bundle", 32'(bundle()), 32'(26'h0_0000 | {W_J32, A_AND, D_WD, RQ_RT, DW_ALU, DY_EXTS, 6'b0, 2'd0, 2'd0}));

    // Decode table, back to back
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].rt, vecs[i].fn);
      step();
      chk({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
      chk(vecs[i].name, 32'(bundle()), 32'(vecs[i].exp));
    end
    drive(1'b0, 6'b0, 5'd0, 6'b0);
    step();
    chk("bubble_valid", 32'(out_valid), 32'd0);

    // div then mflo presented immediately
    drive(1'b1, 6'b000000, 5'd0, 6'b011010);
    step();
    chk("div_valid", 32'(out_valid), 32'd1);
    chk("div_op", 32'(mdu_op), 32'd2);
    drive(1'b1, 6'b000000, 5'd0, 6'b010010);
    #1;
    bc = 0; pulses = 0; blocked = 0; guard = 0;
    while (mdu_busy && guard < 100) begin
      bc++;
      pulses += int'(mdu_start);
      if (!in_ready) blocked++;
      step();
      guard++;
    end
    chk("div_timeout", 32'(guard < 100), 32'd1);
    chk("div_busy_cycles", 32'(bc), 32'd32);
    chk("div_start_pulses", 32'(pulses), 32'd1);
    chk("mflo_blocked_cycles", 32'(blocked), 32'd32);
    chk("mflo_ready_after", 32'(in_ready), 32'd1);
    chk("mflo_not_yet_valid", 32'(out_valid), 32'd0);
    step();
    chk("mflo_valid", 32'(out_valid), 32'd1);
    chk("mflo_hilo_rd", 32'(hilo_rd), 32'd2);
    chk("mflo_wrf", 32'(w_en_regfile), 32'd1);

    // mult followed by independent lw
    drive(1'b1, 6'b000000, 5'd0, 6'b011000);
    step();
    chk("mult_start", 32'({mdu_start, mdu_op, mdu_busy}), 32'b1001);
    drive(1'b1, 6'b100011, 5'd0, 6'b000000);
    #1;
    chk("lw_ready", 32'(in_ready), 32'd1);
    step();
    chk("lw_fields", 32'({out_valid, mux_regfile_data_w, op_datamem, mdu_start, mdu_busy}), 32'b1_01_000_0_1);
    drive(1'b0, 6'b0, 5'd0, 6'b0);
    bc = 2; guard = 0;
    while (guard < 20) begin
      step();
      guard++;
      if (mdu_busy) bc++;
      else break;
    end
    chk("mult_busy_cycles", 32'(bc), 32'd3);

    // beq, stall, then stall+flush
    drive(1'b1, 6'b000100, 5'd0, 6'b000000);
    step();
    chk("beq_loaded", 32'({out_valid, is_branch, op_wtg}), 32'({1'b1, 1'b1, W_BEQ}));
    drive(1'b1, 6'b101011, 5'd0, 6'b000000);
    stall = 1'b1;
    step();
    chk("beq_held", 32'({out_valid, is_branch, op_wtg, w_en_datamem}), 32'({1'b1, 1'b1, W_BEQ, 1'b0}));
    flush = 1'b1;
    step();
    chk("flushed", 32'({out_valid, is_branch}), 32'd0);
    stall = 1'b0; flush = 1'b0;
    drive(1'b0, 6'b0, 5'd0, 6'b0);

    // multu held by stall: start must not repeat; flush does not abort RUN
    drive(1'b1, 6'b000000, 5'd0, 6'b011001);
    step();
    chk("multu_start", 32'({mdu_start, mdu_op}), 32'b101);
    drive(1'b0, 6'b0, 5'd0, 6'b0);
    stall = 1'b1;
    step();
    chk("multu_stall_hold", 32'({out_valid, mdu_start, mdu_op}), 32'b1001);
    stall = 1'b0; flush = 1'b1;
    step();
    chk("multu_flush_busy", 32'({out_valid, mdu_busy}), 32'b01);
    flush = 1'b0;
    step();
    chk("multu_done", 32'(mdu_busy), 32'd0);

    // reset mid-div
    drive(1'b1, 6'b000000, 5'd0, 6'b011011);
    step();
    drive(1'b0, 6'b0, 5'd0, 6'b0);
    repeat (5) step();
    chk("divu_busy_mid", 32'(mdu_busy), 32'd1);
    rst = 1'b1;
    step();
    chk("rst_mid_div", 32'({mdu_busy, out_valid}), 32'd0);
    rst = 1'b0;
    drive(1'b1, 6'b000000, 5'd0, 6'b010000);
    #1;
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    step();
    chk("mfhi_after_rst", 32'({out_valid, hilo_rd, mdu_busy}), 32'b1010);
    drive(1'b0, 6'b0, 5'd0, 6'b0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
